// File: rtl/sort_pkg.sv
// ---------------------------------------------------------------------------
// sort_pkg
// Shared types and helpers for the serial_sorter block.
//   sort_state_t : sequencer states (LOAD, SORT, DRAIN)
//   idx_width()  : width of the word/compare/pass indices for an N-word block
//   DEF_W/DEF_N  : default word width and block size
// ---------------------------------------------------------------------------
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } sort_state_t;

    localparam int DEF_W = 4;
    localparam int DEF_N = 4;

    // Index width for a block of n words. Never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mag_cmp.sv
// ---------------------------------------------------------------------------
// mag_cmp
// Unsigned W-bit magnitude comparator. Exactly one output is high.
//   a, b : operands (unsigned)
//   gt   : a > b
//   eq   : a == b
//   lt   : a < b
// ---------------------------------------------------------------------------
module mag_cmp #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/serial_sorter.sv
// ---------------------------------------------------------------------------
// serial_sorter
// Accepts a block of N unsigned W-bit words, bubble-sorts it in place with a
// single shared comparator (one compare-and-swap per cycle, early exit on a
// pass without swaps) and streams it out smallest first.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_data is the word
//   out_valid/out_ready : output handshake, out_data is the word
//   out_last            : final (largest) word of the block
//   busy                : high while sorting or draining
// ---------------------------------------------------------------------------
module serial_sorter
    import sort_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int IW = idx_width(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] LAST_CMP = IW'(N - 2);
    localparam logic [IW-1:0] ONE      = IW'(1);

    sort_state_t   state, state_nxt;
    logic [IW-1:0] wr_idx, rd_idx, cmp_idx, pass;
    logic          swapped;
    logic [W-1:0]  word_buf [N];

    logic [IW-1:0] cmp_idx_p1;
    logic [W-1:0]  left, right;
    logic          gt, eq, lt;
    logic          unused_cmp;
    logic          pass_end, swapped_any;
    logic          in_fire, out_fire;

    // cmp_idx never exceeds N-2, so cmp_idx+1 always lands inside the buffer.
    assign cmp_idx_p1 = cmp_idx + ONE;
    assign left       = word_buf[cmp_idx];
    assign right      = word_buf[cmp_idx_p1];
    assign unused_cmp = eq ^ lt;

    mag_cmp #(.W(W)) u_cmp (
        .a  (left),
        .b  (right),
        .gt (gt),
        .eq (eq),
        .lt (lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs depend only on registered state and indices; the handshake
    // inputs only feed the fire strobes and next-state terms.
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        busy        = 1'b0;
        in_fire     = 1'b0;
        out_fire    = 1'b0;
        pass_end    = (cmp_idx == LAST_CMP);
        // Early exit must see this cycle's swap, not just earlier ones.
        swapped_any = swapped | gt;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                in_fire  = in_valid;
                if (in_valid && (wr_idx == LAST_IDX)) begin
                    state_nxt = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                if (pass_end && (!swapped_any || (pass == LAST_CMP))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = word_buf[rd_idx];
                out_last  = (rd_idx == LAST_IDX);
                out_fire  = out_ready;
                if (out_ready && (rd_idx == LAST_IDX)) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            cmp_idx <= '0;
            pass    <= '0;
            swapped <= 1'b0;
            for (int i = 0; i < N; i++) begin
                word_buf[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        word_buf[wr_idx] <= in_data;
                        if (wr_idx == LAST_IDX) begin
                            wr_idx  <= '0;
                            cmp_idx <= '0;
                            pass    <= '0;
                            swapped <= 1'b0;
                        end else begin
                            wr_idx <= wr_idx + ONE;
                        end
                    end
                end
                SORT: begin
                    // Strictly-greater swap keeps equal words in order.
                    if (gt) begin
                        word_buf[cmp_idx]    <= right;
                        word_buf[cmp_idx_p1] <= left;
                    end
                    if (!pass_end) begin
                        cmp_idx <= cmp_idx + ONE;
                        swapped <= swapped_any;
                    end else if (state_nxt == SORT) begin
                        pass    <= pass + ONE;
                        cmp_idx <= '0;
                        swapped <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sorter.sv
// ---------------------------------------------------------------------------
// tb_serial_sorter
// Directed, table-driven bench for serial_sorter (N=4, W=4) plus a second
// instance with N=2 for the minimum block size.
// ---------------------------------------------------------------------------
module tb_serial_sorter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [3:0] in_data, out_data;

    logic       d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_out_last, d2_busy;
    logic [3:0] d2_in_data, d2_out_data;

    int cyc = 0;
    int hs_cyc;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] din  [4];
        logic [3:0] dout [4];
        int         passes;
        bit         stall;
    } vec_t;

    vec_t tbl [6];

    serial_sorter #(.W(4), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    serial_sorter #(.W(4), .N(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d2_in_valid),
        .in_ready  (d2_in_ready),
        .in_data   (d2_in_data),
        .out_valid (d2_out_valid),
        .out_ready (d2_out_ready),
        .out_data  (d2_out_data),
        .out_last  (d2_out_last),
        .busy      (d2_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"},  out_last,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_out_data"},  out_data,  0);
    endtask

    task automatic load_block(input int t);
        for (int i = 0; i < 4; i++) begin
            check("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = tbl[t].din[i];
            step();
        end
        in_valid = 1'b0;
        hs_cyc   = cyc;
    endtask

    // Latency counts the cycle of the last input handshake as cycle 0.
    task automatic wait_valid(input int exp_lat);
        int guard;
        guard = 0;
        while (!out_valid && guard < 40) begin
            check("busy_sort", busy, 1);
            step();
            guard++;
        end
        if (!out_valid) check("wait_valid_timeout", 0, 1);
        else            check("latency", cyc - hs_cyc + 1, exp_lat);
    endtask

    task automatic drain(input int t, input bit stall);
        int         k;
        int         guard;
        logic [3:0] d;
        logic       l;
        k = 0;
        guard = 0;
        while (k < 4 && guard < 200) begin
            guard++;
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            d = out_data;
            l = out_last;
            check("out_valid_held", out_valid, 1);
            step();
            if (out_ready) begin
                check("out_data", d, tbl[t].dout[k]);
                check("out_last", l, (k == 3) ? 1 : 0);
                k++;
            end else begin
                check("stall_data_stable", out_data, d);
                check("stall_last_stable", out_last, l);
            end
        end
        out_ready = 1'b0;
        if (k < 4) check("drain_timeout", k, 4);
        check("in_ready_after_last", in_ready, 1);
        check("out_valid_after_last", out_valid, 0);
    endtask

    initial begin
        tbl[0].din = '{4'd0, 4'd1, 4'd2, 4'd3};  tbl[0].dout = '{4'd0, 4'd1, 4'd2, 4'd3};
        tbl[0].passes = 1; tbl[0].stall = 1'b0;
        tbl[1].din = '{4'd3, 4'd2, 4'd1, 4'd0};  tbl[1].dout = '{4'd0, 4'd1, 4'd2, 4'd3};
        tbl[1].passes = 3; tbl[1].stall = 1'b0;
        tbl[2].din = '{4'd5, 4'd5, 4'd2, 4'd5};  tbl[2].dout = '{4'd2, 4'd5, 4'd5, 4'd5};
        tbl[2].passes = 3; tbl[2].stall = 1'b0;
        tbl[3].din = '{4'd15, 4'd0, 4'd15, 4'd0}; tbl[3].dout = '{4'd0, 4'd0, 4'd15, 4'd15};
        tbl[3].passes = 3; tbl[3].stall = 1'b1;
        // All-equal block: any swap of equal words would force extra passes.
        tbl[4].din = '{4'd7, 4'd7, 4'd7, 4'd7};  tbl[4].dout = '{4'd7, 4'd7, 4'd7, 4'd7};
        tbl[4].passes = 1; tbl[4].stall = 1'b0;
        tbl[5].din = '{4'd1, 4'd0, 4'd3, 4'd2};  tbl[5].dout = '{4'd0, 4'd1, 4'd2, 4'd3};
        tbl[5].passes = 2; tbl[5].stall = 1'b0;

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        d2_in_valid  = 1'b0;
        d2_in_data   = '0;
        d2_out_ready = 1'b0;

        step();
        step();
        check_reset("rst_held");
        rst_n = 1'b1;
        step();
        check_reset("rst_released");

        for (int t = 0; t < 5; t++) begin
            load_block(t);
            wait_valid(tbl[t].passes * 3 + 1);
            drain(t, tbl[t].stall);
        end

        // Reset while sorting 3,2,1,0.
        load_block(1);
        step();
        step();
        check("busy_before_rst_sort", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_sort_async");
        step();
        rst_n = 1'b1;
        step();
        check_reset("rst_sort_after");

        // Reset while draining 3,2,1,0, after one word has left.
        load_block(1);
        wait_valid(10);
        out_ready = 1'b1;
        check("drain_first", out_data, 0);
        step();
        out_ready = 1'b0;
        check("drain_second", out_data, 1);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_drain_async");
        step();
        rst_n = 1'b1;
        step();
        check_reset("rst_drain_after");

        // Fresh block after the aborted ones.
        load_block(5);
        wait_valid(tbl[5].passes * 3 + 1);
        drain(5, 1'b0);

        // N=2 instance: one compare, two-cycle latency.
        check("n2_in_ready", d2_in_ready, 1);
        d2_in_valid = 1'b1;
        d2_in_data  = 4'd9;
        step();
        d2_in_data  = 4'd4;
        step();
        d2_in_valid = 1'b0;
        hs_cyc = cyc;
        begin
            int guard;
            guard = 0;
            while (!d2_out_valid && guard < 20) begin
                step();
                guard++;
            end
            if (!d2_out_valid) check("n2_timeout", 0, 1);
            else               check("n2_latency", cyc - hs_cyc + 1, 2);
        end
        d2_out_ready = 1'b1;
        check("n2_data0", d2_out_data, 4);
        check("n2_last0", d2_out_last, 0);
        step();
        check("n2_data1", d2_out_data, 9);
        check("n2_last1", d2_out_last, 1);
        step();
        d2_out_ready = 1'b0;
        check("n2_in_ready_after", d2_in_ready, 1);
        check("n2_out_valid_after", d2_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_sorter.md
# serial_sorter

Multi-cycle ascending sorter for blocks of `N` unsigned `W`-bit words, built around a single shared magnitude comparator. It accepts a block on a valid/ready input stream and sorts it in place with a bubble-sort sequencer, one compare-and-swap per cycle, stopping early once a pass makes no swap. It then streams the sorted block out on a valid/ready output. It sits between a producer and consumer that both use valid/ready flow control.

## Interface

Parameters:
- `W`, 4: data word width in bits; unsigned.
- `N`, 4: words per block; must be 2 or more.

Ports:
- `clk`, input, 1: the only clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: producer presents `in_data`.
- `in_ready`, output, 1: sorter accepts a word this cycle.
- `in_data`, input, `W`: unsigned input word.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: consumer accepts `out_data`.
- `out_data`, output, `W`: sorted word, smallest first.
- `out_last`, output, 1: marks the final (largest) word of the block while `out_valid` is high.
- `busy`, output, 1: high in SORT and DRAIN.

## Operation

- State machine with three states: LOAD, SORT, DRAIN. Reset state is LOAD.
- LOAD
  - `in_ready`=1.
  - Each `in_valid && in_ready` cycle writes `buf[wr_idx]` and increments `wr_idx`.
  - The write that fills `buf[N-1]` moves the state to SORT and clears `wr_idx`, `cmp_idx`, `pass` and `swapped`.
- SORT
  - Each cycle the comparator examines `buf[cmp_idx]` against `buf[cmp_idx+1]`.
  - Swap only when the left word is strictly greater. Equal words are never swapped, so the sort is stable.
  - A swap sets `swapped`.
  - When `cmp_idx` < `N-2`, `cmp_idx` increments.
  - When `cmp_idx` = `N-2`, the pass ends:
    - Go to DRAIN if no swap occurred in this pass (including the current cycle), or if `pass` = `N-2`.
    - Otherwise `pass` increments, `cmp_idx` returns to 0 and `swapped` clears.
  - The early-exit check for a pass uses that pass's `swapped` value OR'd with the current cycle's swap decision.
- DRAIN
  - `out_valid`=1 and `out_data`=`buf[rd_idx]`.
  - `out_last`=1 when `rd_idx`=`N-1`.
  - Each `out_valid && out_ready` increments `rd_idx`.
  - The handshake with `out_last`=1 clears `rd_idx` and returns to LOAD.
- Load and drain of different blocks never overlap. `in_ready`=0 throughout SORT and DRAIN.
- Arithmetic
  - All comparisons are unsigned.
  - `wr_idx`, `rd_idx` and `cmp_idx` are `$clog2(N)` bits wide.
  - `pass` is `$clog2(N)` bits wide, with a minimum of 1.
  - No index ever wraps past `N-1`; every terminal value is detected explicitly.

## Timing

- Reset values while `rst_n`=0, and immediately after it deasserts:
  - `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0.
  - `out_data`=0, and all buffer entries are 0.
- `in_ready`, `out_valid`, `out_last`, `busy` and `out_data` are decoded from registered state and index only. There is no combinational path from `in_valid` or `out_ready`.
- Throughput: at most one word per cycle in and one word per cycle out.
- Latency from the Nth input handshake to the first `out_valid`=1 is P×(N-1)+1 cycles, where P is the number of passes executed (1 ≤ P ≤ N-1). For N=4, best case is 4 cycles and worst case is 10.
- After the final output handshake, `in_ready`=1 on the next cycle.
- Backpressure
  - While `out_ready`=0, `out_data` and `out_last` remain stable.
  - `out_valid` never drops before the handshake completes.
- Reset mid-operation, in any state: the block aborts immediately.
  - Partial block data is discarded.
  - The state returns to LOAD with all outputs at their reset values.

## Structure

- Package `sort_pkg` holds:
  - the state enum `sort_state_t` (LOAD, SORT, DRAIN);
  - localparams for the index widths.
- One sub-module, `mag_cmp`: a `W`-bit unsigned compare producing `gt`, `eq` and `lt`, with exactly one output high.
  - It is instantiated once, on the `buf[cmp_idx]` / `buf[cmp_idx+1]` mux outputs.
  - Swap condition = `gt`.

## Test plan

- N=4, W=4. Load 0,1,2,3 with `out_ready`=1.
  - Expect one pass (3 SORT cycles) and `out_valid` 4 cycles after the last load.
  - Output 0,1,2,3, with `out_last` on 3.
- Load 3,2,1,0.
  - Expect 3 passes (9 SORT cycles).
  - Output 0,1,2,3.
- Load 5,5,2,5.
  - Expect no swaps between equal values.
  - Output 2,5,5,5.
- Load 15,0,15,0.
  - Output 0,0,15,15.
  - Toggle `out_ready` randomly; `out_data` must stay stable while stalled, with no loss or duplication.
  - Next-block `in_ready` rises exactly 1 cycle after the 4th output handshake.
- Assert `rst_n`=0 during SORT and again during DRAIN of the block 3,2,1,0.
  - Outputs return to reset values asynchronously.
  - A fresh block 1,0,3,2 then sorts correctly to 0,1,2,3.
- Set N=2 and load 9,4.
  - Expect a single compare and a 2-cycle latency.
  - Output 4,9.
